mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one line-wide memory
// port between the instruction cache (requester 0) and the data cache
// (requester 1). A granted command is latched and run to completion before
// the next grant is made.
module mem_port_arbiter #(
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 28
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic                 r0_read_i,
  input  logic                 r0_wr_i,
  input  logic [ADDR_BITS-1:0] r0_address_i,
  input  logic [LINE_BITS-1:0] r0_write_data_i,
  output logic [LINE_BITS-1:0] r0_read_data_o,
  output logic                 r0_busywait_o,
  output logic                 r0_done_o,

  input  logic                 r1_read_i,
  input  logic                 r1_wr_i,
  input  logic [ADDR_BITS-1:0] r1_address_i,
  input  logic [LINE_BITS-1:0] r1_write_data_i,
  output logic [LINE_BITS-1:0] r1_read_data_o,
  output logic                 r1_busywait_o,
  output logic                 r1_done_o,

  output logic                 m_read_o,
  output logic                 m_wr_o,
  output logic [ADDR_BITS-1:0] m_address_o,
  output logic [LINE_BITS-1:0] m_write_data_o,
  input  logic [LINE_BITS-1:0] m_read_data_i,
  input  logic                 m_busywait_i,
  input  logic                 m_read_done_i,
  input  logic                 m_write_done_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 lastGnt_q, lastGnt_d;
  logic                 cmdWr_q, cmdWr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] r0Data_q, r0Data_d;
  logic [LINE_BITS-1:0] r1Data_q, r1Data_d;

  logic r0Pend, r1Pend, winner, complete;

  assign r0Pend = r0_read_i | r0_wr_i;
  assign r1Pend = r1_read_i | r1_wr_i;

  // On a tie the requester that was not served last wins; otherwise the lone requester wins.
  assign winner = (r0Pend & r1Pend) ? ~lastGnt_q : r1Pend;

  // Memory finishes only once it is no longer busy and reports the matching done.
  assign complete = ~m_busywait_i & (cmdWr_q ? m_write_done_i : m_read_done_i);

  // A requester stalls while its request is up, except in its own done cycle.
  assign r0_busywait_o = r0Pend & ~((state_q == DONE) & ~gnt_q);
  assign r1_busywait_o = r1Pend & ~((state_q == DONE) & gnt_q);

  assign r0_read_data_o = r0Data_q;
  assign r1_read_data_o = r1Data_q;

  // State, grant history, latched command and returned read lines.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      lastGnt_q <= 1'b1;
      cmdWr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      r0Data_q  <= '0;
      r1Data_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      lastGnt_q <= lastGnt_d;
      cmdWr_q   <= cmdWr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      r0Data_q  <= r0Data_d;
      r1Data_q  <= r1Data_d;
    end
  end

  // Grant in IDLE, drive memory in BUSY, pulse done for one cycle in DONE.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    lastGnt_d      = lastGnt_q;
    cmdWr_d        = cmdWr_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    r0Data_d       = r0Data_q;
    r1Data_d       = r1Data_q;
    m_read_o       = 1'b0;
    m_wr_o         = 1'b0;
    m_address_o    = '0;
    m_write_data_o = '0;
    r0_done_o      = 1'b0;
    r1_done_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (r0Pend | r1Pend) begin
          state_d   = BUSY;
          gnt_d     = winner;
          lastGnt_d = winner;
          if (winner) begin
            cmdWr_d = r1_wr_i;
            addr_d  = r1_address_i;
            wdata_d = r1_write_data_i;
          end else begin
            cmdWr_d = r0_wr_i;
            addr_d  = r0_address_i;
            wdata_d = r0_write_data_i;
          end
        end
      end

      BUSY: begin
        m_address_o    = addr_q;
        m_write_data_o = wdata_q;
        m_read_o       = ~cmdWr_q & ~m_read_done_i;
        m_wr_o         = cmdWr_q & ~m_write_done_i;
        if (complete) begin
          state_d = DONE;
          if (!cmdWr_q) begin
            if (gnt_q) r1Data_d = m_read_data_i;
            else       r0Data_d = m_read_data_i;
          end
        end
      end

      DONE: begin
        state_d   = IDLE;
        r0_done_o = ~gnt_q;
        r1_done_o = gnt_q;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of the two-requester memory arbiter.
module tb_mem_port_arbiter;

  localparam int LB = 128;
  localparam int AB = 28;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_DONE = 2;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          r0_read_i, r0_wr_i, r1_read_i, r1_wr_i;
  logic [AB-1:0] r0_address_i, r1_address_i;
  logic [LB-1:0] r0_write_data_i, r1_write_data_i;
  logic [LB-1:0] r0_read_data_o, r1_read_data_o;
  logic          r0_busywait_o, r0_done_o, r1_busywait_o, r1_done_o;
  logic          m_read_o, m_wr_o;
  logic [AB-1:0] m_address_o;
  logic [LB-1:0] m_write_data_o, m_read_data_i;
  logic          m_busywait_i, m_read_done_i, m_write_done_i;

  int vectors = 0;
  int miscompares = 0;

  logic [LB-1:0] memArr [logic [AB-1:0]];

  mem_port_arbiter #(.LINE_BITS(LB), .ADDR_BITS(AB)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .r0_read_i(r0_read_i), .r0_wr_i(r0_wr_i), .r0_address_i(r0_address_i),
    .r0_write_data_i(r0_write_data_i), .r0_read_data_o(r0_read_data_o),
    .r0_busywait_o(r0_busywait_o), .r0_done_o(r0_done_o),
    .r1_read_i(r1_read_i), .r1_wr_i(r1_wr_i), .r1_address_i(r1_address_i),
    .r1_write_data_i(r1_write_data_i), .r1_read_data_o(r1_read_data_o),
    .r1_busywait_o(r1_busywait_o), .r1_done_o(r1_done_o),
    .m_read_o(m_read_o), .m_wr_o(m_wr_o), .m_address_o(m_address_o),
    .m_write_data_o(m_write_data_o), .m_read_data_i(m_read_data_i),
    .m_busywait_i(m_busywait_i), .m_read_done_i(m_read_done_i),
    .m_write_done_i(m_write_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic idleAll();
    r0_read_i = 0; r0_wr_i = 0; r0_address_i = '0; r0_write_data_i = '0;
    r1_read_i = 0; r1_wr_i = 0; r1_address_i = '0; r1_write_data_i = '0;
    m_read_data_i = '0; m_busywait_i = 0; m_read_done_i = 0; m_write_done_i = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    reset_i = 1'b1;
    idleAll();
    @(negedge clk_i);
    @(negedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  task automatic setReq(input int x, input logic rd, input logic wr,
                        input logic [AB-1:0] a, input logic [LB-1:0] d);
    if (x == 0) begin
      r0_read_i = rd; r0_wr_i = wr; r0_address_i = a; r0_write_data_i = d;
    end else begin
      r1_read_i = rd; r1_wr_i = wr; r1_address_i = a; r1_write_data_i = d;
    end
  endtask

  function automatic logic [LB-1:0] lineFor(input logic [AB-1:0] a);
    if (memArr.exists(a)) return memArr[a];
    return {a, 4'h1, a, 4'h2, a, 4'h3, a, 4'h4};
  endfunction

  // Memory responder: waits for a strobe, answers after doneDelay+1 cycles,
  // holds busywait for busyCycles, and reports the done pulses seen in the done cycle.
  task automatic serveOne(input int doneDelay, input int busyCycles, input logic [LB-1:0] rdata,
                          output logic [AB-1:0] seenAddr, output logic seenWr,
                          output logic timedOut, output logic [1:0] doneSeen);
    timedOut = 1'b1; seenAddr = '0; seenWr = 1'b0; doneSeen = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (m_read_o || m_wr_o) begin
        timedOut = 1'b0;
        break;
      end
    end
    if (timedOut) return;
    seenAddr = m_address_o;
    seenWr   = m_wr_o;
    for (int d = 0; d < doneDelay; d++) nextCycle();
    nextCycle();
    m_read_done_i = !seenWr; m_write_done_i = seenWr; m_read_data_i = rdata;
    m_busywait_i = (busyCycles > 0);
    for (int b = 0; b < busyCycles; b++) nextCycle();
    m_busywait_i = 1'b0;
    nextCycle();
    m_read_done_i = 1'b0; m_write_done_i = 1'b0;
    @(negedge clk_i);
    doneSeen = {r1_done_o, r0_done_o};
  endtask

  task automatic test_reset();
    idleAll();
    reset_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if ({m_read_o, m_wr_o, r0_done_o, r1_done_o, r0_busywait_o, r1_busywait_o} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {m_read_o, m_wr_o, r0_done_o, r1_done_o, r0_busywait_o, r1_busywait_o});
    end
    vectors++;
    if (m_address_o !== '0 || m_write_data_o !== '0) begin
      miscompares++; $display("[TB] FAIL reset_mport: got %h/%h want 0", m_address_o, m_write_data_o);
    end
    vectors++;
    if (r0_read_data_o !== '0 || r1_read_data_o !== '0) begin
      miscompares++; $display("[TB] FAIL reset_rdata: got %h/%h want 0", r0_read_data_o, r1_read_data_o);
    end
    #1 reset_i = 1'b0;
    nextCycle();
    @(negedge clk_i);
    vectors++;
    if ({m_read_o, m_wr_o} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL idle_no_req: got %b want 00", {m_read_o, m_wr_o});
    end
  endtask

  task automatic test_read();
    logic [LB-1:0] line = 128'h0123456789ABCDEF0123456789ABCDEF;
    nextCycle();
    setReq(0, 1'b1, 1'b0, 28'h0000010, '0);
    @(negedge clk_i);
    vectors++;
    if ({r0_busywait_o, m_read_o} !== 2'b10) begin
      miscompares++; $display("[TB] FAIL rd_c0: got bw/rd %b want 10", {r0_busywait_o, m_read_o});
    end
    for (int c = 1; c <= 2; c++) begin
      nextCycle();
      @(negedge clk_i);
      vectors++;
      if (m_read_o !== 1'b1 || m_address_o !== 28'h0000010) begin
        miscompares++; $display("[TB] FAIL rd_strobe_c%0d: got %b @%h want 1 @0000010", c, m_read_o, m_address_o);
      end
    end
    nextCycle();
    m_read_done_i = 1'b1; m_read_data_i = line;
    @(negedge clk_i);
    vectors++;
    if ({m_read_o, r0_done_o} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL rd_c3: got rd/done %b want 00", {m_read_o, r0_done_o});
    end
    nextCycle();
    m_read_done_i = 1'b0; m_read_data_i = {4{32'hDEADBEEF}};
    @(negedge clk_i);
    vectors++;
    if ({r0_done_o, r0_busywait_o} !== 2'b10) begin
      miscompares++; $display("[TB] FAIL rd_c4_done: got done/bw %b want 10", {r0_done_o, r0_busywait_o});
    end
    vectors++;
    if (r0_read_data_o !== line) begin
      miscompares++; $display("[TB] FAIL rd_c4_data: got %h want %h", r0_read_data_o, line);
    end
    r0_read_i = 1'b0;
    nextCycle();
    @(negedge clk_i);
    vectors++;
    if (r0_done_o !== 1'b0 || r0_read_data_o !== line) begin
      miscompares++; $display("[TB] FAIL rd_c5_hold: got %b %h want 0 %h", r0_done_o, r0_read_data_o, line);
    end
  endtask

  task automatic test_write();
    logic [LB-1:0] wline = {4{32'hFFFF_0000}};
    nextCycle();
    setReq(1, 1'b0, 1'b1, 28'hABCDEF0, wline);
    @(negedge clk_i);
    nextCycle();
    @(negedge clk_i);
    vectors++;
    if ({m_wr_o, m_read_o} !== 2'b10 || m_address_o !== 28'hABCDEF0 || m_write_data_o !== wline) begin
      miscompares++; $display("[TB] FAIL wr_c1: got %b %h %h want 10 abcdef0 %h", {m_wr_o, m_read_o}, m_address_o, m_write_data_o, wline);
    end
    nextCycle();
    r1_address_i = 28'h1111111; r1_write_data_i = ~wline;
    @(negedge clk_i);
    vectors++;
    if (m_wr_o !== 1'b1 || m_address_o !== 28'hABCDEF0 || m_write_data_o !== wline) begin
      miscompares++; $display("[TB] FAIL wr_latched: got %b %h %h want 1 abcdef0 %h", m_wr_o, m_address_o, m_write_data_o, wline);
    end
    nextCycle();
    m_write_done_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if ({m_wr_o, r1_done_o} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL wr_c3: got wr/done %b want 00", {m_wr_o, r1_done_o});
    end
    nextCycle();
    m_write_done_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if ({r1_done_o, r0_done_o, r1_busywait_o} !== 3'b100) begin
      miscompares++; $display("[TB] FAIL wr_done: got %b want 100", {r1_done_o, r0_done_o, r1_busywait_o});
    end
    vectors++;
    if (r1_read_data_o !== '0 || r0_read_data_o !== 128'h0123456789ABCDEF0123456789ABCDEF) begin
      miscompares++; $display("[TB] FAIL wr_rdata_hold: got %h %h", r1_read_data_o, r0_read_data_o);
    end
    r1_wr_i = 1'b0;
    nextCycle();
    @(negedge clk_i);
    vectors++;
    if (r1_done_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wr_single_pulse: got %b want 0", r1_done_o);
    end
  endtask

  task automatic test_busywait();
    logic [LB-1:0] line = {4{32'h5A5A_C3C3}};
    nextCycle();
    setReq(0, 1'b1, 1'b0, 28'h0000055, '0);
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      if (c == 1) begin
        m_read_done_i = 1'b1; m_busywait_i = 1'b1; m_read_data_i = line;
      end
      @(negedge clk_i);
      vectors++;
      if ({r0_done_o, r0_busywait_o} !== 2'b01) begin
        miscompares++; $display("[TB] FAIL bw_hold_c%0d: got done/bw %b want 01", c, {r0_done_o, r0_busywait_o});
      end
    end
    nextCycle();
    m_busywait_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (r0_done_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bw_release_c6: got %b want 0", r0_done_o);
    end
    nextCycle();
    m_read_done_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (r0_done_o !== 1'b1 || r0_read_data_o !== line) begin
      miscompares++; $display("[TB] FAIL bw_done_c7: got %b %h want 1 %h", r0_done_o, r0_read_data_o, line);
    end
    r0_read_i = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    nextCycle();
    setReq(1, 1'b0, 1'b1, 28'h0DEAD00, {4{32'h1234_5678}});
    nextCycle();
    @(negedge clk_i);
    vectors++;
    if (m_wr_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL rst_pre_busy: got %b want 1", m_wr_o);
    end
    #2;
    reset_i = 1'b1;
    idleAll();
    #1;
    vectors++;
    if ({m_read_o, m_wr_o, r0_done_o, r1_done_o, r0_busywait_o, r1_busywait_o} !== 6'b0) begin
      miscompares++; $display("[TB] FAIL rst_async_ctrl: got %b want 000000",
                              {m_read_o, m_wr_o, r0_done_o, r1_done_o, r0_busywait_o, r1_busywait_o});
    end
    vectors++;
    if (m_address_o !== '0 || m_write_data_o !== '0 || r0_read_data_o !== '0) begin
      miscompares++; $display("[TB] FAIL rst_async_data: got %h %h %h want 0", m_address_o, m_write_data_o, r0_read_data_o);
    end
    @(negedge clk_i);
    #1 reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      @(negedge clk_i);
      vectors++;
      if ({m_read_o, m_wr_o, r0_done_o, r1_done_o} !== 4'b0000) begin
        miscompares++; $display("[TB] FAIL rst_no_done_c%0d: got %b want 0000", c, {m_read_o, m_wr_o, r0_done_o, r1_done_o});
      end
    end
  endtask

  // Runs right after the mid-transaction reset, so the first tie must go to requester 0.
  task automatic test_alternate();
    logic [AB-1:0] addr;
    logic wr, to;
    logic [1:0] ds;
    logic [LB-1:0] rline;
    int expWin;
    nextCycle();
    setReq(0, 1'b1, 1'b0, 28'h00000A0, '0);
    setReq(1, 1'b0, 1'b1, 28'h00000B0, {4{32'hCAFE_F00D}});
    for (int t = 0; t < 4; t++) begin
      expWin = t % 2;
      rline = {4{t[7:0], 24'hA5A5A5}};
      serveOne(t % 2, 0, rline, addr, wr, to, ds);
      vectors++;
      if (to || addr !== (expWin == 0 ? 28'h00000A0 : 28'h00000B0)) begin
        miscompares++; $display("[TB] FAIL alt_grant_%0d: got timeout %b addr %h want winner r%0d", t, to, addr, expWin);
      end
      vectors++;
      if (ds !== (expWin == 0 ? 2'b01 : 2'b10) || (expWin == 0 ? r1_busywait_o : r0_busywait_o) !== 1'b1) begin
        miscompares++; $display("[TB] FAIL alt_done_%0d: got done %b loser bw %b want r%0d done, loser 1", t, ds,
                                (expWin == 0 ? r1_busywait_o : r0_busywait_o), expWin);
      end
      if (expWin == 0) begin
        vectors++;
        if (r0_read_data_o !== rline) begin
          miscompares++; $display("[TB] FAIL alt_rdata_%0d: got %h want %h", t, r0_read_data_o, rline);
        end
      end
      if (t == 3) begin
        idleAll();
      end else begin
        setReq(expWin, 1'b0, 1'b0, '0, '0);
        nextCycle();
        if (expWin == 0) setReq(0, 1'b1, 1'b0, 28'h00000A0, '0);
        else             setReq(1, 1'b0, 1'b1, 28'h00000B0, {4{32'hCAFE_F00D}});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AB-1:0] addr;
    logic wr, to;
    logic [1:0] ds;
    nextCycle();
    setReq(0, 1'b1, 1'b0, 28'h0000100, '0);
    nextCycle();
    setReq(1, 1'b1, 1'b0, 28'h0000200, '0);
    serveOne(0, 0, {4{32'h1111_0000}}, addr, wr, to, ds);
    vectors++;
    if (to || addr !== 28'h0000100 || ds !== 2'b01) begin
      miscompares++; $display("[TB] FAIL b2b_first: got %b %h %b want 0 0000100 01", to, addr, ds);
    end
    r0_read_i = 1'b0;
    nextCycle();
    setReq(0, 1'b1, 1'b0, 28'h0000101, '0);
    serveOne(1, 1, {4{32'h2222_0000}}, addr, wr, to, ds);
    vectors++;
    if (to || addr !== 28'h0000200 || ds !== 2'b10 || r1_read_data_o !== {4{32'h2222_0000}}) begin
      miscompares++; $display("[TB] FAIL b2b_r1_between: got %b %h %b %h want 0 0000200 10", to, addr, ds, r1_read_data_o);
    end
    r1_read_i = 1'b0;
    serveOne(0, 0, {4{32'h3333_0000}}, addr, wr, to, ds);
    vectors++;
    if (to || addr !== 28'h0000101 || ds !== 2'b01 || r0_read_data_o !== {4{32'h3333_0000}}) begin
      miscompares++; $display("[TB] FAIL b2b_second: got %b %h %b %h want 0 0000101 01", to, addr, ds, r0_read_data_o);
    end
    idleAll();
  endtask

  task automatic test_random();
    int phase, serving, lastServed, lat, doneCnt;
    int cool [2];
    logic pend [2];
    logic reqRd [2];
    logic reqWr [2];
    logic [AB-1:0] reqAddr [2];
    logic [LB-1:0] reqData [2];
    logic [LB-1:0] expRd [2];
    logic cmdWr, rdIn, wdIn, bwIn, expBw0, expBw1;
    logic [AB-1:0] cmdAddr;
    logic [LB-1:0] cmdData;
    logic [31:0] rnd;
    doReset();
    phase = P_IDLE; serving = 0; lastServed = 1; lat = 0; doneCnt = 0;
    cmdWr = 0; cmdAddr = '0; cmdData = '0; rdIn = 0; wdIn = 0; bwIn = 0;
    for (int x = 0; x < 2; x++) begin
      cool[x] = 0; pend[x] = 0; reqRd[x] = 0; reqWr[x] = 0;
      reqAddr[x] = '0; reqData[x] = '0; expRd[x] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      nextCycle();
      if (phase == P_DONE) begin
        pend[serving] = 1'b0;
        cool[serving] = int'($urandom_range(0, 3));
        setReq(serving, 1'b0, 1'b0, '0, '0);
      end
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && !(phase == P_DONE && x == serving)) begin
          if (cool[x] > 0) cool[x]--;
          else if ($urandom_range(0, 2) == 0) begin
            rnd = $urandom;
            reqAddr[x] = 28'h1230000 | {25'd0, rnd[2:0]};
            reqRd[x] = (rnd[5:4] != 2'd1);
            reqWr[x] = (rnd[5:4] == 2'd1) || (rnd[5:4] == 2'd2);
            reqData[x] = {$urandom, $urandom, $urandom, $urandom};
            pend[x] = 1'b1;
            setReq(x, reqRd[x], reqWr[x], reqAddr[x], reqData[x]);
          end
        end
      end
      if (phase == P_BUSY) begin
        rnd = $urandom;
        setReq(serving, reqRd[serving], reqWr[serving], rnd[AB-1:0], {4{rnd}});
        if (lat > 0) begin
          lat--; rdIn = 1'b0; wdIn = 1'b0;
        end else begin
          rdIn = !cmdWr; wdIn = cmdWr;
        end
        bwIn = ($urandom_range(0, 3) == 0);
        m_read_data_i = rdIn ? lineFor(cmdAddr) : {$urandom, $urandom, $urandom, $urandom};
      end else begin
        rdIn = ($urandom_range(0, 3) == 0);
        wdIn = ($urandom_range(0, 3) == 0);
        bwIn = ($urandom_range(0, 3) == 0);
        m_read_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      m_read_done_i = rdIn; m_write_done_i = wdIn; m_busywait_i = bwIn;
      @(negedge clk_i);
      expBw0 = pend[0] && !(phase == P_DONE && serving == 0);
      expBw1 = pend[1] && !(phase == P_DONE && serving == 1);
      vectors++;
      if ({r1_busywait_o, r0_busywait_o} !== {expBw1, expBw0}) begin
        miscompares++; $display("[TB] FAIL rnd_busywait cyc %0d: got %b want %b", cyc, {r1_busywait_o, r0_busywait_o}, {expBw1, expBw0});
      end
      vectors++;
      if (r0_read_data_o !== expRd[0] || r1_read_data_o !== expRd[1]) begin
        miscompares++; $display("[TB] FAIL rnd_rdata cyc %0d: got %h %h want %h %h", cyc, r0_read_data_o, r1_read_data_o, expRd[0], expRd[1]);
      end
      case (phase)
        P_IDLE: begin
          vectors++;
          if ({m_read_o, m_wr_o, r0_done_o, r1_done_o} !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL rnd_idle cyc %0d: got %b want 0000", cyc, {m_read_o, m_wr_o, r0_done_o, r1_done_o});
          end
          if (pend[0] || pend[1]) begin
            serving = (pend[0] && pend[1]) ? 1 - lastServed : (pend[1] ? 1 : 0);
            lastServed = serving;
            cmdWr = reqWr[serving]; cmdAddr = reqAddr[serving]; cmdData = reqData[serving];
            lat = int'($urandom_range(0, 3));
            phase = P_BUSY;
          end
        end
        P_BUSY: begin
          vectors++;
          if (m_read_o !== (!cmdWr && !rdIn) || m_wr_o !== (cmdWr && !wdIn) || m_address_o !== cmdAddr ||
              {r0_done_o, r1_done_o} !== 2'b00) begin
            miscompares++; $display("[TB] FAIL rnd_busy cyc %0d: got rd %b wr %b @%h want rd %b wr %b @%h (r%0d)", cyc,
                                    m_read_o, m_wr_o, m_address_o, !cmdWr && !rdIn, cmdWr && !wdIn, cmdAddr, serving);
          end
          if (cmdWr) begin
            vectors++;
            if (m_write_data_o !== cmdData) begin
              miscompares++; $display("[TB] FAIL rnd_wdata cyc %0d: got %h want %h", cyc, m_write_data_o, cmdData);
            end
          end
          if (!bwIn && (cmdWr ? wdIn : rdIn)) begin
            if (cmdWr) memArr[cmdAddr] = cmdData;
            else       expRd[serving] = lineFor(cmdAddr);
            phase = P_DONE;
          end
        end
        default: begin
          vectors++;
          if ({r1_done_o, r0_done_o} !== (serving == 1 ? 2'b10 : 2'b01) || {m_read_o, m_wr_o} !== 2'b00) begin
            miscompares++; $display("[TB] FAIL rnd_done cyc %0d: got done %b strobes %b want r%0d, 00", cyc,
                                    {r1_done_o, r0_done_o}, {m_read_o, m_wr_o}, serving);
          end
          doneCnt++;
          phase = P_IDLE;
        end
      endcase
    end
    vectors++;
    if (doneCnt < 40) begin
      miscompares++; $display("[TB] FAIL rnd_progress: got %0d completions want >= 40", doneCnt);
    end
    idleAll();
  endtask

  initial begin
    idleAll();
    test_reset();
    test_read();
    test_write();
    test_busywait();
    test_reset_mid_busy();
    test_alternate();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
